render_scan_controller: RTL
===========================

RENDER_SCAN_CONTROLLER -- requirements
Module: render_scan_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 160: pixels per line; legal range 2..256.
REQ-002 SHALL have parameter HEIGHT, default 120: lines per frame; legal range 2..128.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port frameClk, input, 1 bit: frame-rate strobe; a rising edge requests one frame render.
REQ-006 SHALL have port gameState, input, 2 bits: 0 MENU, 1 RUNNING, 2 PAUSE, 3 OVER.
REQ-007 SHALL have ports renderX and renderY, outputs, 8 bits each: pixel coordinate driven to all four state renderers.
REQ-008 SHALL have ports colMenu, colRun, colPause and colOver, inputs, 3 bits each: registered renderer colours, valid 1 cycle after renderX/renderY.
REQ-009 SHALL have ports vgaX (8 bits), vgaY (7 bits) and vgaColor (3 bits), outputs: VGA adapter write address and data.
REQ-010 SHALL have port vgaPlot, output, 1 bit: write enable for the VGA adapter.
REQ-011 SHALL have ports busy and frameDone, outputs, 1 bit each: busy = frame in progress; frameDone = 1-cycle pulse when a frame completes.
REQ-012 SHALL have port overrunCount, output, 8 bits; this port exists only when FRAME_OVERRUN_CNT_EN is defined.

Function
REQ-013 SHALL detect a frameClk rising edge by comparing frameClk with a registered copy of frameClk (frameClkPrev).
REQ-014 SHALL implement FSM states IDLE, SCAN and DRAIN.
REQ-015 In IDLE, a detected edge at cycle T SHALL latch gameState into curState; at T+1 the FSM SHALL be in SCAN with renderX=0, renderY=0.
REQ-016 In SCAN, per cycle:
- renderX SHALL increment by 1.
- When renderX==WIDTH-1, renderX SHALL wrap to 0 and renderY SHALL increment.
- After the cycle with (WIDTH-1, HEIGHT-1), the FSM SHALL enter DRAIN.
REQ-017 The coordinate presented at cycle t SHALL appear on vgaX/vgaY at t+1, with vgaPlot=1 at t+1: a 1-cycle registered pipeline.
REQ-018 vgaColor SHALL be a combinational mux of colMenu/colRun/colPause/colOver selected by curState, aligned with vgaPlot.
REQ-019 DRAIN SHALL last 1 cycle and carry the final plot; the FSM SHALL then return to IDLE with frameDone=1 for exactly that 1 cycle.
REQ-020 Frame latency: first plot at T+2, last plot at T+1+WIDTH*HEIGHT, frameDone at T+2+WIDTH*HEIGHT; exactly WIDTH*HEIGHT plots per frame, each coordinate once, in raster order.
REQ-021 busy SHALL be 1 in SCAN and DRAIN and 0 in IDLE.
REQ-022 vgaPlot SHALL be 0 whenever no pipeline entry is valid.
REQ-023 gameState changes during SCAN/DRAIN SHALL NOT affect the current frame; curState is held until the next start.
REQ-024 A frameClk edge detected while busy=1 SHALL be dropped: no queued frame, no restart.
REQ-025 An edge detected in the frameDone cycle (FSM already IDLE) SHALL start a new frame normally.
REQ-026 Coordinate arithmetic SHALL be unsigned 8-bit; vgaY SHALL be renderY[6:0].

Reset
REQ-027 While resetn=0 at a clk edge, the block SHALL set: FSM=IDLE, renderX=renderY=0, vgaX=vgaY=0, vgaPlot=0, frameDone=0, curState=0 and overrunCount=0.
REQ-028 On reset, frameClkPrev SHALL be set to 1, so a frameClk held high through reset release does not start a frame.
REQ-029 Reset mid-frame SHALL abort the frame with no further plots and no frameDone pulse.

Configuration
REQ-030 With FRAME_OVERRUN_CNT_EN defined:
- overrunCount SHALL increment on each edge dropped per REQ-024.
- overrunCount SHALL saturate at 255.
REQ-031 Without FRAME_OVERRUN_CNT_EN: the port and the counter SHALL be absent; all other behaviour is unchanged.

Verification (WIDTH=4, HEIGHT=3 unless noted)
REQ-032 frameClk edge at T, gameState=1, colRun=3'b101 -> 12 plots at T+2..T+13 in order (0,0),(1,0)..(3,2), all vgaColor=3'b101; frameDone pulse at T+14 only.
REQ-033 gameState switched 1->3 at T+5 -> every vgaColor in the frame equals colRun; the next frame uses colOver.
REQ-034 Second frameClk edge at T+6 -> no restart, 12 plots total; overrunCount=1 with FRAME_OVERRUN_CNT_EN, port absent without it.
REQ-035 resetn=0 at T+7 -> vgaPlot=0 from T+8, busy=0, no frameDone; frameClk held high across reset release -> no frame starts.
REQ-036 Default 160x120, one frame -> 19200 plots; last plot at (159,119); frameDone at T+19202.
REQ-037 Edge in the frameDone cycle -> new frame enters SCAN the next cycle with (0,0).

Source files
------------

// File: rtl/render_scan_controller.sv
// Frame scan controller: on a frameClk rising edge, rasters every pixel through the active
// renderer and streams coordinate/colour writes to the VGA adapter. Option: FRAME_OVERRUN_CNT_EN.
module render_scan_controller #(
    parameter int unsigned WIDTH  = 160,
    parameter int unsigned HEIGHT = 120
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frameClk,
    input  logic [1:0] gameState,
    output logic [7:0] renderX,
    output logic [7:0] renderY,
    input  logic [2:0] colMenu,
    input  logic [2:0] colRun,
    input  logic [2:0] colPause,
    input  logic [2:0] colOver,
    output logic [7:0] vgaX,
    output logic [6:0] vgaY,
    output logic [2:0] vgaColor,
    output logic       vgaPlot,
    output logic       busy,
    output logic       frameDone
`ifdef FRAME_OVERRUN_CNT_EN
    ,
    output logic [7:0] overrunCount
`endif
);

    localparam logic [7:0] XLast = 8'(WIDTH - 1);
    localparam logic [7:0] YLast = 8'(HEIGHT - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDrain} state_t;

    state_t     state;
    logic       frame_clk_prev;
    logic [1:0] cur_state;
    logic       frame_edge;

    assign frame_edge = frameClk & ~frame_clk_prev;
    assign busy       = (state != StIdle);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= StIdle;
            frame_clk_prev <= 1'b1;  // a level held high through reset is not an edge
            cur_state      <= 2'd0;
            renderX        <= 8'd0;
            renderY        <= 8'd0;
            vgaX           <= 8'd0;
            vgaY           <= 7'd0;
            vgaPlot        <= 1'b0;
            frameDone      <= 1'b0;
        end else begin
            frame_clk_prev <= frameClk;
            frameDone      <= 1'b0;
            vgaPlot        <= 1'b0;
            case (state)
                StIdle: begin
                    if (frame_edge) begin
                        cur_state <= gameState;
                        renderX   <= 8'd0;
                        renderY   <= 8'd0;
                        state     <= StScan;
                    end
                end
                StScan: begin
                    vgaX    <= renderX;
                    vgaY    <= renderY[6:0];
                    vgaPlot <= 1'b1;
                    if (renderX == XLast) begin
                        renderX <= 8'd0;
                        if (renderY == YLast) begin
                            renderY <= 8'd0;
                            state   <= StDrain;
                        end else begin
                            renderY <= renderY + 8'd1;
                        end
                    end else begin
                        renderX <= renderX + 8'd1;
                    end
                end
                StDrain: begin
                    state     <= StIdle;
                    frameDone <= 1'b1;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Renderer colours are registered, so they line up with the delayed write address.
    always_comb begin
        vgaColor = colMenu;
        unique case (cur_state)
            2'd0: vgaColor = colMenu;
            2'd1: vgaColor = colRun;
            2'd2: vgaColor = colPause;
            2'd3: vgaColor = colOver;
        endcase
    end

`ifdef FRAME_OVERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overrunCount <= 8'd0;
        end else if (frame_edge && busy && (overrunCount != 8'hFF)) begin
            overrunCount <= overrunCount + 8'd1;
        end
    end
`endif

endmodule
